syn_accumulator: RTL and testbench

Parametrised synaptic weight accumulator for one neuron. It holds a table of NUM_SYN (source address, IEEE-754 single weight) entries and records incoming spikes by source address during a timestep. On the timestep `clear` pulse, it sums the weights of all spiked synapses sequentially through one floating-point adder and presents the total to the potential-update stage. It supersedes the fixed 5-synapse accumulator with configurable depth, one-cycle-per-term sequential accumulation, and an explicit valid/busy handshake.

---
 rtl/syn_acc_pkg.sv | 29 ++
 rtl/fp_add32.sv | 101 ++++++++++
 rtl/syn_accumulator.sv | 152 +++++++++++++++
 tb/tb_syn_accumulator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/syn_acc_pkg.sv
// syn_acc_pkg: shared types, constants and helpers for the synaptic
// weight accumulator.
//   state_t    : accumulator FSM states
//   WEIGHT_W   : IEEE-754 single width
//   MAX_SYN    : largest supported table depth
//   FP_ZERO    : +0.0 encoding
//   lowest_set : index of the lowest set bit of a mask (0 when empty)
package syn_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WEIGHT_W = 32;
  localparam int MAX_SYN  = 64;
  localparam logic [WEIGHT_W-1:0] FP_ZERO = 32'h0000_0000;

  function automatic int lowest_set(input logic [MAX_SYN-1:0] v);
    int r;
    r = 0;
    for (int i = MAX_SYN - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_add32.sv
// fp_add32: combinational IEEE-754 single-precision adder, round to
// nearest even, with subnormal support.
// Ports:
//   a, b      in  operands
//   result    out a + b
//   exception out invalid operation (NaN operand, inf - inf) or overflow
module fp_add32
  import syn_acc_pkg::*;
(
  input  logic [WEIGHT_W-1:0] a,
  input  logic [WEIGHT_W-1:0] b,
  output logic                exception,
  output logic [WEIGHT_W-1:0] result
);

  logic        a_nan, b_nan, a_inf, b_inf, swap, eff_sub, found, rup;
  logic [31:0] big, sml;
  logic [7:0]  e_big, e_sml, d;
  logic [26:0] m_big, m_sml, m_sh, norm;
  logic [27:0] sum28;
  logic [9:0]  exp_n, sh;
  logic [4:0]  lz;
  logic [24:0] m_rnd;

  always_comb begin
    result    = FP_ZERO;
    exception = 1'b0;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

    // Order by magnitude so the larger operand sets sign and exponent.
    swap  = (b[30:0] > a[30:0]);
    big   = swap ? b : a;
    sml   = swap ? a : b;
    e_big = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    e_sml = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    // 24-bit significand followed by guard, round and sticky positions.
    m_big = {(big[30:23] != 8'd0), big[22:0], 3'b000};
    m_sml = {(sml[30:23] != 8'd0), sml[22:0], 3'b000};
    d     = e_big - e_sml;
    if (d >= 8'd27)
      m_sh = {26'd0, |m_sml};
    else
      m_sh = (m_sml >> d) | {26'd0, |(m_sml & ((27'd1 << d) - 27'd1))};

    eff_sub = big[31] ^ sml[31];
    sum28   = eff_sub ? ({1'b0, m_big} - {1'b0, m_sh})
                      : ({1'b0, m_big} + {1'b0, m_sh});

    norm  = 27'd0;
    exp_n = {2'b00, e_big};
    lz    = 5'd0;
    found = 1'b0;
    sh    = 10'd0;
    if (sum28[27]) begin
      norm  = {sum28[27:2], sum28[1] | sum28[0]};
      exp_n = exp_n + 10'd1;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (sum28[i]) found = 1'b1;
          else          lz    = lz + 5'd1;
        end
      end
      // Never shift below the minimum exponent; the rest stays subnormal.
      sh    = ({5'd0, lz} > (exp_n - 10'd1)) ? (exp_n - 10'd1) : {5'd0, lz};
      norm  = sum28[26:0] << sh;
      exp_n = exp_n - sh;
    end

    rup   = norm[2] & (norm[1] | norm[0] | norm[3]);
    m_rnd = {1'b0, norm[26:3]} + {24'd0, rup};
    if (m_rnd[24]) begin
      m_rnd = m_rnd >> 1;
      exp_n = exp_n + 10'd1;
    end

    if (a_nan || b_nan) begin
      result    = 32'h7FC0_0000;
      exception = 1'b1;
    end else if (a_inf && b_inf && (a[31] != b[31])) begin
      result    = 32'h7FC0_0000;
      exception = 1'b1;
    end else if (a_inf) begin
      result = a;
    end else if (b_inf) begin
      result = b;
    end else if (sum28 == 28'd0) begin
      // Exact cancellation gives +0; -0 only from adding two -0 values.
      result = {~eff_sub & big[31], 31'd0};
    end else if (exp_n >= 10'd255) begin
      result    = {big[31], 8'hFF, 23'd0};
      exception = 1'b1;
    end else begin
      result = {big[31], (m_rnd[23] ? exp_n[7:0] : 8'd0), m_rnd[22:0]};
    end
  end

endmodule

// File: rtl/syn_accumulator.sv
// syn_accumulator: synaptic weight accumulator for one neuron. Spikes are
// matched against a (source address, weight) table and latched as pending;
// a clear pulse snapshots them and sums the matching weights, one add per
// cycle in ascending entry order.
// Ports:
//   CLK, RESETN                  clock, synchronous active-low reset
//   init_valid/index/source_address/weight   table write (ignored while busy)
//   spike_valid, source_address  incoming spike
//   clear                        end-of-timestep pulse
//   busy, out_valid, acc_out     accumulation status and result
//   overrun                      sticky, clear seen while not idle
//   acc_exc                      adder exception during the timestep
// Build option: define SYN_ACC_EXC_EN to enable acc_exc; otherwise it is 0.
//
// state | meaning
// IDLE  | collecting spikes, waiting for clear
// ACCUM | adding one snapshotted weight per cycle
// DONE  | acc_out valid, out_valid pulse
module syn_accumulator #(
  parameter int NUM_SYN  = 8,
  parameter int ADDR_W   = 12,
  parameter int WEIGHT_W = 32
) (
  input  logic                       CLK,
  input  logic                       RESETN,
  input  logic                       init_valid,
  input  logic [$clog2(NUM_SYN)-1:0] init_index,
  input  logic [ADDR_W-1:0]          init_source_address,
  input  logic [WEIGHT_W-1:0]        init_weight,
  input  logic                       spike_valid,
  input  logic [ADDR_W-1:0]          source_address,
  input  logic                       clear,
  output logic                       busy,
  output logic                       out_valid,
  output logic [WEIGHT_W-1:0]        acc_out,
  output logic                       overrun,
  output logic                       acc_exc
);
  import syn_acc_pkg::*;

  localparam int IDX_W = $clog2(NUM_SYN);

  logic [ADDR_W-1:0]   tab_addr [NUM_SYN];
  logic [WEIGHT_W-1:0] tab_w    [NUM_SYN];
  logic [NUM_SYN-1:0]  tab_v, pending, work, match;
  logic [WEIGHT_W-1:0] sum, add_res;
  logic                add_exc;
  logic [IDX_W-1:0]    sel;
  state_t              state, state_nxt;
  logic                accept_clear, add_en, finish;

  // Matching uses the registered table, so a same-cycle init write is not seen.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SYN; i++)
      match[i] = spike_valid && tab_v[i] && (tab_addr[i] == source_address);
  end

  assign sel = IDX_W'(lowest_set(MAX_SYN'(work)));

  fp_add32 u_add (
    .a         (sum),
    .b         (tab_w[sel]),
    .exception (add_exc),
    .result    (add_res)
  );

  always_comb begin
    state_nxt    = state;
    accept_clear = 1'b0;
    add_en       = 1'b0;
    finish       = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          accept_clear = 1'b1;
          state_nxt    = ACCUM;
        end
      end
      ACCUM: begin
        if (work == '0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          add_en = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state == ACCUM);
  assign out_valid = (state == DONE);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state   <= IDLE;
      tab_v   <= '0;
      pending <= '0;
      work    <= '0;
      sum     <= FP_ZERO;
      acc_out <= FP_ZERO;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_SYN; i++) begin
        tab_addr[i] <= '0;
        tab_w[i]    <= '0;
      end
    end else begin
      state <= state_nxt;
      if (init_valid && !busy && (int'(init_index) < NUM_SYN)) begin
        tab_addr[init_index] <= init_source_address;
        tab_w[init_index]    <= init_weight;
        tab_v[init_index]    <= 1'b1;
      end
      if (accept_clear) begin
        work    <= pending | match;
        pending <= '0;
        sum     <= FP_ZERO;
      end else begin
        pending <= pending | match;
      end
      if (add_en) begin
        sum       <= add_res;
        work[sel] <= 1'b0;
      end
      // Loaded on entry to DONE so the result is valid alongside out_valid.
      if (finish) acc_out <= sum;
      if (clear && (state != IDLE)) overrun <= 1'b1;
    end
  end

`ifdef SYN_ACC_EXC_EN
  logic exc_flag;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      exc_flag <= 1'b0;
      acc_exc  <= 1'b0;
    end else begin
      if (accept_clear)  exc_flag <= 1'b0;
      else if (add_en)   exc_flag <= exc_flag | add_exc;
      if (finish) acc_exc <= exc_flag;
    end
  end
`else
  logic exc_unused;
  assign exc_unused = add_exc;
  assign acc_exc    = 1'b0;
`endif

endmodule

// File: tb/tb_syn_accumulator.sv
module tb_syn_accumulator;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        init_valid = 1'b0;
  logic [2:0]  init_index = 3'd0;
  logic [11:0] init_source_address = 12'd0;
  logic [31:0] init_weight = 32'd0;
  logic        spike_valid = 1'b0;
  logic [11:0] source_address = 12'd0;
  logic        clear = 1'b0;
  logic        busy, out_valid, overrun, acc_exc;
  logic [31:0] acc_out;

  int total = 0;
  int bad   = 0;

`ifdef SYN_ACC_EXC_EN
  localparam logic EXC_EXP = 1'b1;
`else
  localparam logic EXC_EXP = 1'b0;
`endif

  syn_accumulator #(.NUM_SYN(8), .ADDR_W(12), .WEIGHT_W(32)) dut (
    .CLK                 (CLK),
    .RESETN              (RESETN),
    .init_valid          (init_valid),
    .init_index          (init_index),
    .init_source_address (init_source_address),
    .init_weight         (init_weight),
    .spike_valid         (spike_valid),
    .source_address      (source_address),
    .clear               (clear),
    .busy                (busy),
    .out_valid           (out_valid),
    .acc_out             (acc_out),
    .overrun             (overrun),
    .acc_exc             (acc_exc)
  );

  always #5 CLK = ~CLK;

  task automatic init_entry(input logic [2:0] idx, input logic [11:0] a, input logic [31:0] w);
    init_valid = 1'b1; init_index = idx; init_source_address = a; init_weight = w;
    @(negedge CLK);
    init_valid = 1'b0;
  endtask

  task automatic spike(input logic [11:0] a);
    spike_valid = 1'b1; source_address = a;
    @(negedge CLK);
    spike_valid = 1'b0;
  endtask

  // Pulses clear (optionally with a spike in the same and the next cycle),
  // returns the cycle index of out_valid relative to the clear cycle, the
  // captured acc_out, and whether busy was high exactly until out_valid.
  // Ends one cycle after out_valid so a back-to-back clear is legal.
  task automatic clear_and_wait(input logic sp_now, input logic [11:0] a_now,
                                input logic sp_next, input logic [11:0] a_next,
                                output int n, output logic [31:0] acc, output logic busy_ok);
    n = 0; acc = 32'hDEAD_BEEF; busy_ok = 1'b1;
    clear = 1'b1; spike_valid = sp_now; source_address = a_now;
    for (int i = 1; i <= 100; i++) begin
      @(negedge CLK);
      clear = 1'b0;
      if (i == 1) begin spike_valid = sp_next; source_address = a_next; end
      else spike_valid = 1'b0;
      if (out_valid) begin
        n = i; acc = acc_out;
        if (busy) busy_ok = 1'b0;
        break;
      end else if (!busy) busy_ok = 1'b0;
    end
    spike_valid = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;
    @(negedge CLK);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    total++; if (acc_out !== 32'h0) begin bad++; $display("FAIL reset_acc_out: got %h expected 00000000", acc_out); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    total++; if (acc_exc !== 1'b0) begin bad++; $display("FAIL reset_acc_exc: got %b expected 0", acc_exc); end
  endtask

  task automatic test_basic();
    int n; logic [31:0] acc; logic ok;
    init_entry(3'd0, 12'h010, 32'h3F80_0000);
    init_entry(3'd1, 12'h011, 32'h4000_0000);
    init_entry(3'd2, 12'h012, 32'h3F00_0000);
    init_entry(3'd3, 12'h013, 32'h4040_0000);
    spike(12'h010);
    spike(12'h012);
    clear_and_wait(1'b0, 12'h0, 1'b0, 12'h0, n, acc, ok);
    total++; if (n !== 4) begin bad++; $display("FAIL basic_latency: got %0d expected 4", n); end
    total++; if (acc !== 32'h3FC0_0000) begin bad++; $display("FAIL basic_sum: got %h expected 3fc00000", acc); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b expected 1", ok); end
    total++; if (acc_exc !== 1'b0) begin bad++; $display("FAIL basic_exc: got %b expected 0", acc_exc); end
    repeat (3) @(negedge CLK);
    total++; if (acc_out !== 32'h3FC0_0000) begin bad++; $display("FAIL basic_hold: got %h expected 3fc00000", acc_out); end
  endtask

  task automatic test_empty();
    int n; logic [31:0] acc; logic ok;
    clear_and_wait(1'b0, 12'h0, 1'b0, 12'h0, n, acc, ok);
    total++; if (n !== 2) begin bad++; $display("FAIL empty_latency: got %0d expected 2", n); end
    total++; if (acc !== 32'h0) begin bad++; $display("FAIL empty_sum: got %h expected 00000000", acc); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL empty_busy: got %b expected 1", ok); end
  endtask

  task automatic test_duplicate();
    int n; logic [31:0] acc; logic ok;
    init_entry(3'd0, 12'h020, 32'h3F80_0000);
    init_entry(3'd5, 12'h020, 32'h4000_0000);
    spike(12'h020);
    clear_and_wait(1'b0, 12'h0, 1'b0, 12'h0, n, acc, ok);
    total++; if (n !== 4) begin bad++; $display("FAIL dup_latency: got %0d expected 4", n); end
    total++; if (acc !== 32'h4040_0000) begin bad++; $display("FAIL dup_sum: got %h expected 40400000", acc); end
  endtask

  task automatic test_back_to_back();
    int n; logic [31:0] acc; logic ok;
    clear_and_wait(1'b1, 12'h011, 1'b1, 12'h011, n, acc, ok);
    total++; if (n !== 3) begin bad++; $display("FAIL same_cycle_latency: got %0d expected 3", n); end
    total++; if (acc !== 32'h4000_0000) begin bad++; $display("FAIL same_cycle_sum: got %h expected 40000000", acc); end
    clear_and_wait(1'b0, 12'h0, 1'b0, 12'h0, n, acc, ok);
    total++; if (n !== 3) begin bad++; $display("FAIL next_cycle_latency: got %0d expected 3", n); end
    total++; if (acc !== 32'h4000_0000) begin bad++; $display("FAIL next_cycle_sum: got %h expected 40000000", acc); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_fp();
    int n; logic [31:0] acc; logic ok;
    init_entry(3'd6, 12'h030, 32'h3F80_0000);
    init_entry(3'd7, 12'h030, 32'h3380_0000);
    spike(12'h030);
    clear_and_wait(1'b0, 12'h0, 1'b0, 12'h0, n, acc, ok);
    total++; if (acc !== 32'h3F80_0000) begin bad++; $display("FAIL fp_tie_even: got %h expected 3f800000", acc); end
    init_entry(3'd7, 12'h030, 32'h3380_0001);
    spike(12'h030);
    clear_and_wait(1'b0, 12'h0, 1'b0, 12'h0, n, acc, ok);
    total++; if (acc !== 32'h3F80_0001) begin bad++; $display("FAIL fp_round_up: got %h expected 3f800001", acc); end
    init_entry(3'd6, 12'h031, 32'h7F00_0000);
    init_entry(3'd7, 12'h031, 32'h7F00_0000);
    spike(12'h031);
    clear_and_wait(1'b0, 12'h0, 1'b0, 12'h0, n, acc, ok);
    total++; if (acc !== 32'h7F80_0000) begin bad++; $display("FAIL fp_overflow: got %h expected 7f800000", acc); end
    total++; if (acc_exc !== EXC_EXP) begin bad++; $display("FAIL fp_overflow_exc: got %b expected %b", acc_exc, EXC_EXP); end
    init_entry(3'd6, 12'h032, 32'h4040_0000);
    init_entry(3'd7, 12'h032, 32'hBF80_0000);
    spike(12'h032);
    clear_and_wait(1'b0, 12'h0, 1'b0, 12'h0, n, acc, ok);
    total++; if (acc !== 32'h4000_0000) begin bad++; $display("FAIL fp_subtract: got %h expected 40000000", acc); end
    total++; if (acc_exc !== 1'b0) begin bad++; $display("FAIL fp_exc_cleared: got %b expected 0", acc_exc); end
  endtask

  task automatic test_overrun();
    int n; logic [31:0] acc; logic ok;
    spike(12'h011);
    spike(12'h013);
    n = 0; acc = 32'hDEAD_BEEF;
    clear = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge CLK);
      clear = 1'b0; spike_valid = 1'b0; init_valid = 1'b0;
      if (i == 2) begin
        clear = 1'b1; spike_valid = 1'b1; source_address = 12'h012;
        init_valid = 1'b1; init_index = 3'd2; init_source_address = 12'h012; init_weight = 32'h4080_0000;
      end
      if (out_valid) begin n = i; acc = acc_out; break; end
    end
    total++; if (n !== 4) begin bad++; $display("FAIL overrun_latency: got %0d expected 4", n); end
    total++; if (acc !== 32'h40A0_0000) begin bad++; $display("FAIL overrun_sum: got %h expected 40a00000", acc); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
    @(negedge CLK);
    clear_and_wait(1'b0, 12'h0, 1'b0, 12'h0, n, acc, ok);
    total++; if (n !== 3) begin bad++; $display("FAIL carried_latency: got %0d expected 3", n); end
    total++; if (acc !== 32'h3F00_0000) begin bad++; $display("FAIL carried_sum: got %h expected 3f000000", acc); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_reset_mid();
    int n; logic [31:0] acc; logic ok;
    spike(12'h011);
    spike(12'h013);
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
    @(negedge CLK);
    RESETN = 1'b0;
    @(negedge CLK);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
    total++; if (acc_out !== 32'h0) begin bad++; $display("FAIL rst_mid_acc_out: got %h expected 00000000", acc_out); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_mid_overrun: got %b expected 0", overrun); end
    RESETN = 1'b1;
    @(negedge CLK);
    spike(12'h010);
    clear_and_wait(1'b0, 12'h0, 1'b0, 12'h0, n, acc, ok);
    total++; if (n !== 2) begin bad++; $display("FAIL rst_table_latency: got %0d expected 2", n); end
    total++; if (acc !== 32'h0) begin bad++; $display("FAIL rst_table_sum: got %h expected 00000000", acc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_duplicate();
    test_back_to_back();
    test_fp();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
